nios_system_onchip_mem_arbiter: RTL and testbench

//  Two-master Avalon-MM arbiter in front of the single-port on-chip RAM (32b, 1-cycle read latency).

---
 rtl/nios_system_onchip_mem_arbiter_pkg.sv | 21 ++
 rtl/nios_system_onchip_mem_arbiter_if.sv | 57 +++++
 rtl/nios_system_onchip_mem_arbiter_rr_arb2.sv | 64 ++++++
 rtl/nios_system_onchip_mem_arbiter.sv | 106 ++++++++++
 tb/tb_nios_system_onchip_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_onchip_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package : onchip_arb_pkg
//  Brief   : Shared types and constants for the on-chip RAM two-master arbiter
//  Rev     : 1.0  initial release
// ============================================================================
package onchip_arb_pkg;

  // Arbiter FSM: free arbitration, or grant pinned to one master for RMW
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  // Master index encoding used for grant and read-return ownership
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage : onchip_arb_pkg
`default_nettype wire

// File: rtl/nios_system_onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interfaces : onchip_avmm_if, onchip_ram_if
//  Brief      : Avalon-MM master port bundle and on-chip RAM port bundle
//  Rev        : 1.0  initial release
// ============================================================================

// One Avalon-MM requester as seen by the arbiter
interface onchip_avmm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                lock;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
endinterface : onchip_avmm_if

// Single-port RAM with 1-cycle read latency
interface onchip_ram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface : onchip_ram_if
`default_nettype wire

// File: rtl/nios_system_onchip_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module : onchip_rr_arb2
//  Brief  : Two-way round-robin picker with lock hold for read-modify-write
//  Rev    : 1.0  initial release
// ============================================================================
module onchip_rr_arb2
  import onchip_arb_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [1:0] req_i,
  input  wire logic [1:0] lock_i,
  output logic            grant_valid_o,
  output logic            grant_idx_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  // State and last-winner registers; last_q = M1 so m0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Same-cycle grant plus next-state; a grant is always an accepted transfer
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = M0;
    state_d       = state_q;

    unique case (state_q)
      LOCK0: begin
        grant_valid_o = req_i[0];
        grant_idx_o   = M0;
        // Either an accepted unlocked transfer or an idle cycle with lock low
        if (!lock_i[0]) state_d = ARB;
      end
      LOCK1: begin
        grant_valid_o = req_i[1];
        grant_idx_o   = M1;
        if (!lock_i[1]) state_d = ARB;
      end
      default: begin
        grant_valid_o = |req_i;
        if (req_i[0] && req_i[1]) grant_idx_o = ~last_q;
        else if (req_i[1])        grant_idx_o = M1;
        else                      grant_idx_o = M0;
        if (grant_valid_o && lock_i[grant_idx_o])
          state_d = (grant_idx_o == M1) ? LOCK1 : LOCK0;
      end
    endcase

    last_d = grant_valid_o ? grant_idx_o : last_q;
  end

endmodule : onchip_rr_arb2
`default_nettype wire

// File: rtl/nios_system_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : nios_system_onchip_mem_arbiter
//  Brief  : Two-master Avalon-MM arbiter in front of a 1-cycle on-chip RAM
//  Rev    : 1.0  initial release
// ============================================================================
module nios_system_onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 50000,
  parameter logic [DATA_W-1:0] OOR_DATA = '0
) (
  input  wire logic     clk,
  input  wire logic     reset,
  onchip_avmm_if.slave  m0,
  onchip_avmm_if.slave  m1,
  onchip_ram_if.master  mem
);

  // One extra bit so DEPTH == 2**ADDR_W is still representable
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]          req_w;
  logic                grant_valid_w;
  logic                grant_idx_w;
  logic [ADDR_W-1:0]   sel_addr_w;
  logic                sel_read_w;
  logic                sel_write_w;
  logic                in_range_w;
  logic                rd_accept_w;
  logic [DATA_W-1:0]   rd_data_w;
  logic                valid0_w, valid1_w;

  logic                rd_pend_q, rd_pend_d;
  logic                rd_owner_q, rd_owner_d;
  logic                rd_oor_q, rd_oor_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  assign req_w = {m1.read | m1.write, m0.read | m0.write};

  onchip_rr_arb2 u_rr_arb2 (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req_w),
    .lock_i        ({m1.lock, m0.lock}),
    .grant_valid_o (grant_valid_w),
    .grant_idx_o   (grant_idx_w)
  );

  // Granted master's command drives the RAM
  assign sel_addr_w  = (grant_idx_w == M1) ? m1.address : m0.address;
  assign sel_read_w  = (grant_idx_w == M1) ? m1.read    : m0.read;
  assign sel_write_w = (grant_idx_w == M1) ? m1.write   : m0.write;
  assign in_range_w  = {1'b0, sel_addr_w} < DEPTH_C;

  assign mem.address    = sel_addr_w;
  assign mem.byteenable = (grant_idx_w == M1) ? m1.byteenable : m0.byteenable;
  assign mem.writedata  = (grant_idx_w == M1) ? m1.writedata  : m0.writedata;
  assign mem.chipselect = grant_valid_w & in_range_w;
  assign mem.write      = grant_valid_w & sel_write_w & in_range_w;
  assign mem.clken      = 1'b1;

  assign m0.waitrequest = req_w[0] & ~(grant_valid_w & (grant_idx_w == M0));
  assign m1.waitrequest = req_w[1] & ~(grant_valid_w & (grant_idx_w == M1));

  // Read+write together counts as a write, so it never returns data
  assign rd_accept_w = grant_valid_w & sel_read_w & ~sel_write_w;
  assign rd_pend_d   = rd_accept_w;
  assign rd_owner_d  = rd_accept_w ? grant_idx_w : rd_owner_q;
  assign rd_oor_d    = rd_accept_w ? ~in_range_w : rd_oor_q;

  // Return path: the RAM data arrives the cycle after the address
  assign rd_data_w = rd_oor_q ? OOR_DATA : mem.readdata;
  assign valid0_w  = rd_pend_q & (rd_owner_q == M0);
  assign valid1_w  = rd_pend_q & (rd_owner_q == M1);

  assign m0_rdata_d = valid0_w ? rd_data_w : m0_rdata_q;
  assign m1_rdata_d = valid1_w ? rd_data_w : m1_rdata_q;

  assign m0.readdatavalid = valid0_w;
  assign m1.readdatavalid = valid1_w;
  assign m0.readdata      = m0_rdata_d;
  assign m1.readdata      = m1_rdata_d;

  // Read-return pipeline and per-master held readdata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= M0;
      rd_oor_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

endmodule : nios_system_onchip_mem_arbiter
`default_nettype wire

// File: tb/tb_nios_system_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : tb_nios_system_onchip_mem_arbiter
//  Brief  : Directed + random bench with a transaction-level reference model
//  Rev    : 1.0  initial release
// ============================================================================
module tb_nios_system_onchip_mem_arbiter;

  localparam int DEPTH = 50000;

  logic clk;
  logic reset;

  onchip_avmm_if #(.ADDR_W(16), .DATA_W(32)) m0_if ();
  onchip_avmm_if #(.ADDR_W(16), .DATA_W(32)) m1_if ();
  onchip_ram_if  #(.ADDR_W(16), .DATA_W(32)) mem_if ();

  nios_system_onchip_mem_arbiter #(
    .ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .OOR_DATA(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .mem   (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: single port, 1-cycle read latency
  logic [31:0] ram [0:65535];
  logic [31:0] ram_rd;
  assign mem_if.readdata = ram_rd;
  always @(posedge clk) begin
    if (mem_if.clken && mem_if.chipselect) begin
      if (mem_if.write) begin
        for (int b = 0; b < 4; b++)
          if (mem_if.byteenable[b]) ram[mem_if.address][8*b +: 8] <= mem_if.writedata[8*b +: 8];
      end else begin
        ram_rd <= ram[mem_if.address];
      end
    end
  end

  // Reference model: who holds the lock, who won last, expected memory image
  int          n_cmp, n_err;
  int          last_w;
  int          lock_own;
  int          pend_own;
  logic [31:0] pend_dat;
  logic [31:0] last_rd [2];
  logic [31:0] mdl [int];

  function automatic logic [31:0] mdl_read(int a);
    return mdl.exists(a) ? mdl[a] : 32'h0;
  endfunction

  task automatic model_reset();
    last_w   = 1;
    lock_own = -1;
    pend_own = -1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(int m, bit rd, bit wr, bit lk, logic [15:0] a,
                       logic [31:0] d, logic [3:0] be);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.lock = lk;
      m0_if.address = a; m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.lock = lk;
      m1_if.address = a; m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask

  task automatic idle_all();
    drive(0, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 0, 16'h0, 32'h0, 4'h0);
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic cycle();
    bit          rd [2], wr [2], lk [2], rq [2];
    logic [15:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic [31:0] cur;
    int          win;
    bit          inr, ewr;
    @(negedge clk);
    rd[0] = m0_if.read;  wr[0] = m0_if.write; lk[0] = m0_if.lock;
    ad[0] = m0_if.address; wd[0] = m0_if.writedata; be[0] = m0_if.byteenable;
    rd[1] = m1_if.read;  wr[1] = m1_if.write; lk[1] = m1_if.lock;
    ad[1] = m1_if.address; wd[1] = m1_if.writedata; be[1] = m1_if.byteenable;
    rq[0] = rd[0] | wr[0];
    rq[1] = rd[1] | wr[1];

    win = -1;
    if (lock_own >= 0) begin
      if (rq[lock_own]) win = lock_own;
    end else if (rq[0] && rq[1]) win = 1 - last_w;
    else if (rq[0]) win = 0;
    else if (rq[1]) win = 1;
    inr = (win >= 0) && (int'(ad[win]) < DEPTH);
    ewr = (win >= 0) && wr[win] && inr;

    check("m0_waitrequest", 32'(m0_if.waitrequest), 32'(rq[0] && win != 0));
    check("m1_waitrequest", 32'(m1_if.waitrequest), 32'(rq[1] && win != 1));
    check("mem_chipselect", 32'(mem_if.chipselect), 32'(inr));
    check("mem_write", 32'(mem_if.write), 32'(ewr));
    if (inr) check("mem_address", 32'(mem_if.address), 32'(ad[win]));
    if (pend_own >= 0) last_rd[pend_own] = pend_dat;
    check("m0_readdatavalid", 32'(m0_if.readdatavalid), 32'(pend_own == 0));
    check("m1_readdatavalid", 32'(m1_if.readdatavalid), 32'(pend_own == 1));
    check("m0_readdata", m0_if.readdata, last_rd[0]);
    check("m1_readdata", m1_if.readdata, last_rd[1]);

    @(posedge clk);
    pend_own = -1;
    if (!reset) begin
      if (win >= 0) begin
        last_w = win;
        if (wr[win]) begin
          if (inr) begin
            cur = mdl_read(int'(ad[win]));
            for (int b = 0; b < 4; b++)
              if (be[win][b]) cur[8*b +: 8] = wd[win][8*b +: 8];
            mdl[int'(ad[win])] = cur;
          end
        end else begin
          pend_own = win;
          pend_dat = inr ? mdl_read(int'(ad[win])) : 32'h0;
        end
        if (lock_own < 0) begin
          if (lk[win]) lock_own = win;
        end else if (!lk[win]) lock_own = -1;
      end else if (lock_own >= 0 && !lk[lock_own]) begin
        lock_own = -1;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    ram_rd = 32'h0;
    n_cmp = 0;
    n_err = 0;
    model_reset();
    idle_all();
    reset = 1'b1;

    // Reset with no requests
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    cycle();

    // m0 writes, then m1 reads the same word back
    drive(0, 0, 1, 0, 16'h0010, 32'hA5A5_1234, 4'hF);
    cycle();
    idle_all();
    drive(1, 1, 0, 0, 16'h0010, 32'h0, 4'h0);
    cycle();
    idle_all();
    cycle();
    check("t2_m1_readdata_const", m1_if.readdata, 32'hA5A5_1234);

    // Continuous reads from both masters: grants alternate
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 16'(i), 32'h0, 4'h0);
      drive(1, 1, 0, 0, 16'h0010, 32'h0, 4'h0);
      cycle();
    end
    idle_all();
    cycle();

    // m1 locked RMW on 0x20 while m0 keeps requesting
    drive(1, 1, 0, 1, 16'h0020, 32'h0, 4'h0);
    cycle();
    drive(0, 1, 0, 0, 16'h0030, 32'h0, 4'h0);
    drive(1, 0, 0, 1, 16'h0020, 32'h0, 4'h0);
    cycle();
    drive(1, 0, 1, 0, 16'h0020, 32'h1234_5678, 4'hF);
    cycle();
    drive(1, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    cycle();
    idle_all();
    cycle();

    // Out-of-range write is dropped, out-of-range read returns zero
    drive(0, 0, 1, 0, 16'd50000, 32'hDEAD_BEEF, 4'hF);
    cycle();
    drive(0, 1, 0, 0, 16'd50000, 32'h0, 4'h0);
    cycle();
    idle_all();
    cycle();
    check("t5_m0_readdata_const", m0_if.readdata, 32'h0);

    // Reset right after a locked read is accepted
    drive(1, 1, 0, 1, 16'h0010, 32'h0, 4'h0);
    cycle();
    idle_all();
    reset = 1'b1;
    model_reset();
    cycle();
    reset = 1'b0;
    drive(0, 1, 0, 0, 16'h0010, 32'h0, 4'h0);
    drive(1, 1, 0, 0, 16'h0020, 32'h0, 4'h0);
    cycle();
    idle_all();
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        logic [15:0] a;
        int          op;
        a = ($urandom_range(0, 7) == 0) ? 16'(49998 + $urandom_range(0, 5))
                                        : 16'($urandom_range(0, 31));
        op = $urandom_range(0, 9);
        if (op < 4)      drive(m, 1, 0, ($urandom_range(0, 4) == 0), a, 32'h0, 4'h0);
        else if (op < 6) drive(m, 0, 1, ($urandom_range(0, 4) == 0), a, $urandom, 4'($urandom));
        else if (op < 7) drive(m, 1, 1, 1'b0, a, $urandom, 4'($urandom));
        else             drive(m, 0, 0, ($urandom_range(0, 9) == 0), a, 32'h0, 4'h0);
      end
      cycle();
    end
    idle_all();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nios_system_onchip_mem_arbiter
`default_nettype wire
